// File: rtl/uart_pkg.sv
// uart_pkg: shared receiver state encoding, bit-period helper and frame constants
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
  localparam int DATA_BITS = 8;
  function automatic int c_bit(input int freq_hz, input int baud);
    return (freq_hz + baud / 2) / baud;
  endfunction
endpackage

// File: rtl/uart_byte_fifo.sv
// uart_byte_fifo: synchronous first-word-fall-through FIFO with registered head and overflow pulse
module uart_byte_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             overflow
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0] count;
  logic full, do_push, do_pop;
  assign empty = count == '0;
  assign full = count == (AW+1)'(DEPTH);
  assign do_pop = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  // storage array, written at the tail; flushed logically through the pointers
  always_ff @(posedge clk)
    if (do_push) mem[wptr] <= wdata;
  // pointers, occupancy, registered head and overflow pulse
  always_ff @(posedge clk)
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
      rdata <= '0;
      overflow <= 1'b0;
    end else begin
      wptr <= wptr + AW'(do_push);
      rptr <= rptr + AW'(do_pop);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      overflow <= push & full & ~do_pop;
      if (do_pop) rdata <= count == (AW+1)'(1) ? wdata : mem[rptr + 1'b1];
      else if (empty && push) rdata <= wdata;
    end
endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver feeding a byte FIFO; UART_RX_MAJORITY_VOTE_EN enables 3-sample voting
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int G_CLK_FREQ_HZ = 100_000_000,
  parameter int G_BAUD = 115200,
  parameter int G_FIFO_DEPTH = 16,
  parameter int G_SYNC_STAGES = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_uart_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_framing_error,
  output logic       o_overflow,
  output logic       o_busy
);
  localparam int C_BIT = c_bit(G_CLK_FREQ_HZ, G_BAUD);
  localparam int CW = $clog2(C_BIT + 1);
  localparam logic [CW-1:0] HALF = CW'(C_BIT / 2 - 1);
  logic [G_SYNC_STAGES-1:0] sync;
  logic rx_s, done, bit_val, push, empty;
  state_t state;
  logic [CW-1:0] cnt;
  logic [2:0] idx;
  logic [DATA_BITS-1:0] shreg;
  assign rx_s = sync[G_SYNC_STAGES-1];
  // metastability chain on the asynchronous line, idles high
  always_ff @(posedge i_clk)
    sync <= i_rst ? '1 : {sync[G_SYNC_STAGES-2:0], i_uart_rx};
`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam logic [CW-1:0] RELOAD = CW'(C_BIT - 2);
  logic late;
  logic [1:0] votes;
  assign done = late;
  assign bit_val = (votes[1] & votes[0]) | (rx_s & (votes[1] | votes[0]));
  // collect samples at counter 1 and 0, then decide one cycle after counter 0
  always_ff @(posedge i_clk)
    if (i_rst) begin
      late <= 1'b0;
      votes <= '1;
    end else begin
      late <= (state inside {START, DATA, STOP}) && cnt == '0 && !late;
      votes <= {cnt == CW'(1) ? rx_s : votes[1], cnt == '0 ? rx_s : votes[0]};
    end
`else
  localparam logic [CW-1:0] RELOAD = CW'(C_BIT - 1);
  assign done = cnt == '0;
  assign bit_val = rx_s;
`endif
  assign push = state == STOP && done && bit_val;
  assign o_busy = state != IDLE;
  // receiver FSM: start qualification, LSB-first deserialization, stop check
  always_ff @(posedge i_clk)
    if (i_rst) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      shreg <= '0;
      o_framing_error <= 1'b0;
    end else begin
      o_framing_error <= 1'b0;
      if (cnt != '0) cnt <= cnt - 1'b1;
      case (state)
        IDLE: if (!rx_s) begin
          state <= START;
          cnt <= HALF;
        end
        START: if (done) begin
          state <= bit_val ? IDLE : DATA;
          cnt <= RELOAD;
          idx <= '0;
        end
        DATA: if (done) begin
          shreg <= {bit_val, shreg[DATA_BITS-1:1]};
          cnt <= RELOAD;
          idx <= idx + 1'b1;
          if (idx == 3'(DATA_BITS - 1)) state <= STOP;
        end
        STOP: if (done) begin
          state <= bit_val ? IDLE : BREAK;
          o_framing_error <= !bit_val;
        end
        BREAK: if (rx_s) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  uart_byte_fifo #(.WIDTH(DATA_BITS), .DEPTH(G_FIFO_DEPTH)) u_fifo (
    .clk(i_clk),
    .rst(i_rst),
    .push(push),
    .wdata(shreg),
    .pop(i_ready),
    .rdata(o_data),
    .empty(empty),
    .overflow(o_overflow)
  );
  assign o_valid = ~empty;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: self-checking bench for uart_rx_fifo with a shortened bit period
module tb_uart_rx_fifo;
  localparam int FREQ = 1_600_000;
  localparam int BAUD = 100_000;
  localparam int DEPTH = 16;
  localparam int SYNC = 2;
  localparam int C = (FREQ + BAUD / 2) / BAUD;
  localparam int H = C / 2 - 1;
  localparam int LAT = SYNC + 2 + H + 9 * C;
  typedef struct {
    logic [7:0] data;
    bit good;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1, rx = 1'b1, ready = 1'b0;
  logic [7:0] data;
  logic valid, fe, ov, busy;
  int total = 0, bad = 0, cyc = 0, fe_cnt = 0, ov_cnt = 0, t_valid = -1;
  logic valid_q = 1'b0;
  logic [7:0] got[$];
  logic [7:0] expq[$];
  vec_t vt[10];
  always #5 clk = ~clk;
  uart_rx_fifo #(.G_CLK_FREQ_HZ(FREQ), .G_BAUD(BAUD), .G_FIFO_DEPTH(DEPTH), .G_SYNC_STAGES(SYNC)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_uart_rx(rx),
    .o_data(data),
    .o_valid(valid),
    .i_ready(ready),
    .o_framing_error(fe),
    .o_overflow(ov),
    .o_busy(busy)
  );
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (!rst) begin
      if (valid && ready) got.push_back(data);
      if (fe) fe_cnt++;
      if (ov) ov_cnt++;
      if (valid && !valid_q && t_valid < 0) t_valid = cyc;
    end
    valid_q = valid;
  end
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask
  function automatic int getb(input int i);
    return got.size() > i ? int'(got[i]) : -1;
  endfunction
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0] b, input bit good);
    logic [9:0] f;
    f = {good, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = f[i];
      cycles(C);
    end
    if (!good) begin
      cycles(40);
      rx = 1'b1;
      cycles(C);
    end
  endtask
  task automatic cmp_queue(input string name);
    chk({name, "_count"}, got.size(), expq.size());
    for (int i = 0; i < expq.size(); i++) chk($sformatf("%s_byte%0d", name, i), getb(i), expq[i]);
  endtask
  initial begin
    int c0, f0, o0;
    cycles(4);
    rst = 1'b0;
    chk("rst_valid", valid, 0);
    chk("rst_data", data, 0);
    chk("rst_ferr", fe, 0);
    chk("rst_ovf", ov, 0);
    chk("rst_busy", busy, 0);
    ready = 1'b1;
    got.delete();
    c0 = cyc;
    t_valid = -1;
    send(8'h48, 1'b1);
    send(8'h69, 1'b1);
    cycles(4);
    chk("latency", t_valid - c0, LAT);
    expq = '{8'h48, 8'h69};
    cmp_queue("hello");
    chk("hello_ferr", fe_cnt, 0);
    chk("hello_ovf", ov_cnt, 0);
    got.delete();
    rx = 1'b0;
    cycles(5);
    rx = 1'b1;
    cycles(2);
    chk("glitch_busy", busy, 1);
    cycles(C);
    chk("glitch_idle", busy, 0);
    chk("glitch_nopush", got.size(), 0);
    chk("glitch_ferr", fe_cnt, 0);
    f0 = fe_cnt;
    send(8'h55, 1'b0);
    send(8'hA3, 1'b1);
    cycles(4);
    chk("framing_pulses", fe_cnt - f0, 1);
    expq = '{8'hA3};
    cmp_queue("framing");
    got.delete();
    expq.delete();
    f0 = fe_cnt;
    for (int i = 0; i < 10; i++) begin
      vt[i].data = 8'($urandom);
      vt[i].good = $urandom_range(0, 3) != 0;
    end
    for (int i = 0; i < 10; i++) begin
      send(vt[i].data, vt[i].good);
      if (vt[i].good) expq.push_back(vt[i].data);
    end
    cycles(4);
    cmp_queue("rand");
    chk("rand_ferr", fe_cnt - f0, 10 - expq.size());
    ready = 1'b0;
    got.delete();
    expq.delete();
    o0 = ov_cnt;
    for (int i = 0; i < DEPTH; i++) begin
      send(8'(i), 1'b1);
      expq.push_back(8'(i));
    end
    chk("ovf_none_before", ov_cnt - o0, 0);
    send(8'h10, 1'b1);
    chk("ovf_pulse", ov_cnt - o0, 1);
    chk("ovf_head", data, 0);
    ready = 1'b1;
    cycles(DEPTH + 4);
    cmp_queue("ovf_drain");
    ready = 1'b0;
    got.delete();
    expq.delete();
    o0 = ov_cnt;
    for (int i = 0; i < DEPTH; i++) begin
      send(8'h20 + 8'(i), 1'b1);
      expq.push_back(8'h20 + 8'(i));
    end
    fork
      send(8'hC5, 1'b1);
      begin
        cycles(LAT - 1);
        ready = 1'b1;
        cycles(1);
        ready = 1'b0;
      end
    join
    chk("fullpop_ovf", ov_cnt - o0, 0);
    chk("fullpop_popped", got.size(), 1);
    expq.push_back(8'hC5);
    ready = 1'b1;
    cycles(DEPTH + 4);
    cmp_queue("fullpop");
    ready = 1'b0;
    got.delete();
    send(8'h11, 1'b1);
    chk("rstmid_pending", valid, 1);
    begin
      logic [9:0] f;
      f = {1'b1, 8'h5A, 1'b0};
      for (int i = 0; i < 5; i++) begin
        rx = f[i];
        cycles(C);
      end
      rx = f[5];
      cycles(C / 2);
    end
    chk("rstmid_busy_before", busy, 1);
    rst = 1'b1;
    rx = 1'b1;
    cycles(3);
    rst = 1'b0;
    chk("rstmid_valid", valid, 0);
    chk("rstmid_busy", busy, 0);
    ready = 1'b1;
    cycles(C);
    chk("rstmid_flushed", got.size(), 0);
    send(8'h7E, 1'b1);
    cycles(4);
    expq = '{8'h7E};
    cmp_queue("rstmid");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
